bch_enc_ext_ctrl: RTL and testbench

Frame sequencer for the extended BCH encoder. It takes an upstream bit stream with a valid/ready handshake and a per-frame payload length. From these it drives the encoder's strobes (sop/eop/eof/val/dat/clkena) so that each frame is exactly payload bits, then parity slots, then the single even bit. It supports shortened payloads and propagates downstream back-pressure to both the encoder and upstream.

---
 rtl/bch_enc_ext_ctrl_if.sv | 36 +++
 rtl/bch_enc_ext_ctrl.sv | 142 ++++++++++++++
 tb/tb_bch_enc_ext_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bch_enc_ext_ctrl_if.sv
// Upstream handshake, encoder strobes and status
// of the extended BCH encoder frame sequencer.
interface bch_enc_ext_ctrl_if #(
  parameter int W = 5
);
  logic         is_valid;
  logic         is_dat;
  logic         os_ready;
  logic [W-1:0] ik;
  logic         iready;
  logic         oenc_clkena;
  logic         oenc_sop;
  logic         oenc_eop;
  logic         oenc_eof;
  logic         oenc_val;
  logic         oenc_dat;
  logic         obusy;
  logic         oframe_done;
  logic         oerr_cfg;

  modport master (
    output is_valid, is_dat, ik, iready,
    input  os_ready, oenc_clkena, oenc_sop,
    input  oenc_eop, oenc_eof, oenc_val,
    input  oenc_dat, obusy, oframe_done,
    input  oerr_cfg
  );

  modport slave (
    input  is_valid, is_dat, ik, iready,
    output os_ready, oenc_clkena, oenc_sop,
    output oenc_eop, oenc_eof, oenc_val,
    output oenc_dat, obusy, oframe_done,
    output oerr_cfg
  );
endinterface

// File: rtl/bch_enc_ext_ctrl.sv
// Frame sequencer for the extended BCH encoder:
// payload beats, parity beats, then the even bit.
module bch_enc_ext_ctrl #(
  parameter int m     = 4,
  parameter int k_max = 5,
  parameter int n     = 15
) (
  input logic               iclk,
  input logic               ireset_n,
  bch_enc_ext_ctrl_if.slave bus
);
  localparam int W    = m + 1;
  localparam int NPAR = n - k_max;
  localparam logic [W-1:0] KMAX  = W'(k_max);
  localparam logic [W-1:0] PLAST =
    W'((NPAR > 0) ? NPAR - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_PARITY, S_EVEN
  } st_t;

  st_t          state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] kcur_q, kcur_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic beat;
  logic ik_ok;
  logic eop;

  assign beat  = bus.oenc_val & bus.iready;
  assign ik_ok = (bus.ik >= W'(2)) &&
                 (bus.ik <= KMAX);
  assign eop   = (state_q == S_DATA) &&
                 (cnt_q == kcur_q - W'(1));

  // State, counter, length and status registers
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kcur_q  <= KMAX;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kcur_q  <= kcur_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next state: advance only on issued beats
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kcur_d  = kcur_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (beat) begin
          kcur_d  = ik_ok ? bus.ik : KMAX;
          err_d   = ~ik_ok;
          cnt_d   = W'(1);
          busy_d  = 1'b1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          if (eop) begin
            cnt_d = '0;
            if (NPAR == 0) state_d = S_EVEN;
            else           state_d = S_PARITY;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
      end
      S_PARITY: begin
        if (beat) begin
          if (cnt_q == PLAST) begin
            cnt_d   = '0;
            state_d = S_EVEN;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
      end
      S_EVEN: begin
        if (beat) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Strobes: zero-latency decode of state and inputs
  always_comb begin
    bus.os_ready = 1'b0;
    bus.oenc_val = 1'b0;
    bus.oenc_sop = 1'b0;
    bus.oenc_eop = 1'b0;
    bus.oenc_eof = 1'b0;
    bus.oenc_dat = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.os_ready = bus.iready;
        bus.oenc_val = bus.is_valid;
        bus.oenc_sop = 1'b1;
        bus.oenc_dat = bus.is_dat;
      end
      S_DATA: begin
        bus.os_ready = bus.iready;
        bus.oenc_val = bus.is_valid;
        bus.oenc_dat = bus.is_dat;
        bus.oenc_eop = eop;
      end
      S_PARITY: begin
        bus.oenc_val = 1'b1;
      end
      S_EVEN: begin
        bus.oenc_val = 1'b1;
        bus.oenc_eof = 1'b1;
      end
    endcase
  end

  assign bus.oenc_clkena = bus.iready;
  assign bus.obusy       = busy_q;
  assign bus.oframe_done = done_q;
  assign bus.oerr_cfg    = err_q;
endmodule

// File: tb/tb_bch_enc_ext_ctrl.sv
// Directed bench for the extended BCH
// encoder frame sequencer (m=4, k_max=5, n=15).
module tb_bch_enc_ext_ctrl;
  localparam int W = 5;

  logic iclk = 1'b0;
  logic ireset_n = 1'b0;

  bch_enc_ext_ctrl_if #(.W(W)) bus ();

  bch_enc_ext_ctrl #(
    .m(4), .k_max(5), .n(15)
  ) dut (
    .iclk(iclk),
    .ireset_n(ireset_n),
    .bus(bus.slave)
  );

  always #5 iclk = ~iclk;

  int total = 0;
  int bad   = 0;

  logic [4:0] blog [512];
  int nb       = 0;
  int done_n   = 0;
  int err_n    = 0;
  int val0_n   = 0;
  int stab_bad = 0;
  int stall_n  = 0;
  bit chk_stab = 1'b0;
  logic [4:0] prev_stb = '0;
  logic       prev_ird = 1'b1;

  wire [4:0] rec = {bus.oenc_sop, bus.oenc_eop,
                    bus.oenc_eof, bus.oenc_dat,
                    bus.os_ready};
  wire [4:0] stb = {bus.oenc_sop, bus.oenc_eop,
                    bus.oenc_eof, bus.oenc_val,
                    bus.oenc_dat};

  // Beat log and event counters, sampled mid-cycle
  always @(negedge iclk) begin
    if (ireset_n) begin
      if (bus.oenc_val && bus.iready && nb < 512) begin
        blog[nb] <= rec;
        nb <= nb + 1;
      end
      if (bus.oframe_done) done_n <= done_n + 1;
      if (bus.oerr_cfg) err_n <= err_n + 1;
      if (!bus.oenc_val && bus.obusy)
        val0_n <= val0_n + 1;
      if (chk_stab && !bus.iready)
        stall_n <= stall_n + 1;
      if (chk_stab && !prev_ird && stb != prev_stb)
        stab_bad <= stab_bad + 1;
      prev_stb <= stb;
      prev_ird <= bus.iready;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp_v);
    end
  endtask

  task automatic run_frame(input logic [W-1:0] kin,
                           input int nbits,
                           input logic [15:0] pat,
                           input int gap_at,
                           input int gap_len,
                           input bit bp);
    int sent = 0;
    int g = 0;
    int budget = 0;
    int d0 = done_n;
    while (done_n == d0 && budget < 300) begin
      bus.iready = bp ? ($urandom_range(0, 1) != 0)
                      : 1'b1;
      bus.ik = kin;
      if (sent == gap_at && g < gap_len) begin
        bus.is_valid = 1'b0;
        bus.is_dat = 1'b0;
        g++;
      end else if (sent < nbits) begin
        bus.is_valid = 1'b1;
        bus.is_dat = pat[sent];
      end else begin
        bus.is_valid = 1'b0;
        bus.is_dat = 1'b0;
      end
      @(negedge iclk);
      if (bus.is_valid && bus.os_ready) sent++;
      @(posedge iclk);
      #1;
      budget++;
    end
    bus.iready = 1'b1;
    chk("frame_timeout", 32'(budget < 300), 1);
  endtask

  task automatic check_frame(input string tag,
                             input int s,
                             input int nbe,
                             input int eop_e,
                             input int k,
                             input logic [15:0] pat,
                             input int erre,
                             input int d0,
                             input int e0);
    int nbo = nb - s;
    int nsop = 0;
    int neop = 0;
    int neof = 0;
    int feop = -1;
    int feof = -1;
    int ordy_bad = 0;
    int dat_bad = 0;
    for (int i = 0; i < nbo && i < 64; i++) begin
      if (blog[s+i][4]) nsop++;
      if (blog[s+i][3]) begin
        neop++;
        if (feop < 0) feop = i;
      end
      if (blog[s+i][2]) begin
        neof++;
        if (feof < 0) feof = i;
      end
      if (blog[s+i][0] !== (i < k)) ordy_bad++;
      if (i < k && blog[s+i][1] !== pat[i]) dat_bad++;
    end
    $display("%s: beats=%0d", tag, nbo);
    chk({tag, "_beats"}, nbo, nbe);
    chk({tag, "_sop_first"}, 32'(blog[s][4]), 1);
    chk({tag, "_nsop"}, nsop, 1);
    chk({tag, "_eop_idx"}, feop, eop_e);
    chk({tag, "_neop"}, neop, 1);
    chk({tag, "_eof_idx"}, feof, nbe - 1);
    chk({tag, "_neof"}, neof, 1);
    chk({tag, "_os_ready"}, ordy_bad, 0);
    chk({tag, "_payload"}, dat_bad, 0);
    chk({tag, "_done"}, done_n - d0, 1);
    chk({tag, "_err"}, err_n - e0, erre);
    chk({tag, "_busy_after"}, 32'(bus.obusy), 0);
  endtask

  function automatic int same_log(input int a,
                                  input int b,
                                  input int len);
    int diff = 0;
    for (int i = 0; i < len; i++)
      if (blog[a+i] !== blog[b+i]) diff++;
    return diff;
  endfunction

  logic [15:0] p_nom = 16'b10110;
  logic [15:0] p_sh  = 16'b101;
  int s, d0, e0, v0, st0, sb0, s_nom;

  initial begin
    bus.iready = 1'b1;
    bus.is_valid = 1'b0;
    bus.is_dat = 1'b0;
    bus.ik = 5'd5;
    #2;
    chk("rst_busy", 32'(bus.obusy), 0);
    chk("rst_done", 32'(bus.oframe_done), 0);
    chk("rst_err", 32'(bus.oerr_cfg), 0);
    chk("rst_sop", 32'(bus.oenc_sop), 1);
    chk("rst_eop", 32'(bus.oenc_eop), 0);
    chk("rst_eof", 32'(bus.oenc_eof), 0);
    chk("rst_ordy", 32'(bus.os_ready), 1);
    chk("rst_val0", 32'(bus.oenc_val), 0);
    chk("rst_clkena", 32'(bus.oenc_clkena), 1);
    bus.is_valid = 1'b1;
    bus.iready = 1'b0;
    #1;
    chk("rst_val1", 32'(bus.oenc_val), 1);
    chk("rst_ordy_stall", 32'(bus.os_ready), 0);
    chk("rst_clkena0", 32'(bus.oenc_clkena), 0);
    bus.is_valid = 1'b0;
    bus.iready = 1'b1;
    @(posedge iclk); #1;
    @(posedge iclk); #1;
    ireset_n = 1'b1;

    // nominal ik=5: 16 beats
    s = nb; d0 = done_n; e0 = err_n; v0 = val0_n;
    s_nom = s;
    run_frame(5'd5, 5, p_nom, -1, 0, 1'b0);
    check_frame("nom", s, 16, 4, 5, p_nom, 0, d0, e0);
    chk("nom_gaps", val0_n - v0, 0);

    // shortened ik=3: 14 beats
    s = nb; d0 = done_n; e0 = err_n;
    run_frame(5'd3, 3, p_sh, -1, 0, 1'b0);
    check_frame("k3", s, 14, 2, 3, p_sh, 0, d0, e0);

    // illegal lengths fall back to k=5
    s = nb; d0 = done_n; e0 = err_n;
    run_frame(5'd0, 5, p_nom, -1, 0, 1'b0);
    check_frame("ik0", s, 16, 4, 5, p_nom, 1, d0, e0);
    s = nb; d0 = done_n; e0 = err_n;
    run_frame(5'd1, 5, p_nom, -1, 0, 1'b0);
    check_frame("ik1", s, 16, 4, 5, p_nom, 1, d0, e0);
    s = nb; d0 = done_n; e0 = err_n;
    run_frame(5'd7, 5, p_nom, -1, 0, 1'b0);
    check_frame("ik7", s, 16, 4, 5, p_nom, 1, d0, e0);

    // back-pressure: same beats, stable strobes
    s = nb; d0 = done_n; e0 = err_n;
    st0 = stall_n; sb0 = stab_bad;
    chk_stab = 1'b1;
    run_frame(5'd5, 5, p_nom, -1, 0, 1'b1);
    chk_stab = 1'b0;
    check_frame("bp", s, 16, 4, 5, p_nom, 0, d0, e0);
    chk("bp_same_seq", same_log(s, s_nom, 16), 0);
    chk("bp_stalled", 32'(stall_n > st0), 1);
    chk("bp_stable", stab_bad - sb0, 0);

    // upstream gap of 3 cycles before bit 3
    s = nb; d0 = done_n; e0 = err_n; v0 = val0_n;
    run_frame(5'd5, 5, p_nom, 2, 3, 1'b0);
    check_frame("gap", s, 16, 4, 5, p_nom, 0, d0, e0);
    chk("gap_val_low", val0_n - v0, 3);
    chk("gap_same_seq", same_log(s, s_nom, 16), 0);

    // reset during PARITY with cnt=4
    s = nb;
    bus.ik = 5'd5;
    for (int i = 0; i < 9; i++) begin
      bus.is_valid = (i < 5);
      bus.is_dat = (i < 5) ? p_nom[i] : 1'b0;
      @(posedge iclk); #1;
    end
    chk("par_beats", nb - s, 9);
    chk("par_busy", 32'(bus.obusy), 1);
    chk("par_ordy", 32'(bus.os_ready), 0);
    chk("par_val", 32'(bus.oenc_val), 1);
    chk("par_sop", 32'(bus.oenc_sop), 0);
    ireset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.obusy), 0);
    chk("mid_rst_sop", 32'(bus.oenc_sop), 1);
    chk("mid_rst_ordy", 32'(bus.os_ready), 1);
    chk("mid_rst_val", 32'(bus.oenc_val), 0);
    @(posedge iclk); #1;
    ireset_n = 1'b1;
    s = nb; d0 = done_n; e0 = err_n;
    run_frame(5'd5, 5, p_nom, -1, 0, 1'b0);
    check_frame("post_rst", s, 16, 4, 5, p_nom, 0,
                d0, e0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
